// File: rtl/spi_periph_regfile.sv
// SPI mode-0 responder with a 32x8 register file and a local port.
// SCLK/SS_n/MOSI are oversampled on clk_clk; single clock domain.
module spi_periph_regfile #(
  parameter int SYNC_STAGES = 2,
  parameter int STATUS_REG  = 25
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       lcl_wr_en,
  input  logic [4:0] lcl_addr,
  input  logic [7:0] lcl_wdata,
  output logic [7:0] lcl_rdata,
  output logic       spi_wr_strobe,
  output logic [4:0] spi_wr_addr,
  output logic [7:0] spi_wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic sclk_qq_q, sclk_qq_d;
  logic ss_qq_q, ss_qq_d;

  logic sclk_q, mosi_s, ss_sync;
  logic sclk_rise, sclk_fall, ss_fall;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       miso_q, miso_d;
  logic [4:0] ptr_q, ptr_d;
  logic       dir_q, dir_d;

  logic [7:0] regs_q [32];
  logic [7:0] regs_d [32];

  logic [7:0] rdata_q, rdata_d;
  logic       strobe_q, strobe_d;
  logic [4:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       commit;
  logic       boundary;
  logic [7:0] rx_byte;

  assign sclk_q    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_sync   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q & ~sclk_qq_q;
  assign sclk_fall = ~sclk_q & sclk_qq_q;
  assign ss_fall   = ~ss_sync & ss_qq_q;
  assign rx_byte   = {rx_sh_q[6:0], mosi_s};

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = ~ss_sync;
  assign lcl_rdata     = rdata_q;
  assign spi_wr_strobe = strobe_q;
  assign spi_wr_addr   = waddr_q;
  assign spi_wr_data   = wdata_q;

  // synchronizer chains and edge-detect history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    sclk_qq_d   = sclk_q;
    ss_qq_d     = ss_sync;
  end

  // framing FSM: command byte, then data bytes until deselect
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    miso_d    = miso_q;
    ptr_d     = ptr_q;
    dir_d     = dir_q;
    commit    = 1'b0;
    boundary  = 1'b0;
    if (ss_sync) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d   = CMD;
            miso_d    = regs_q[STATUS_REG][7];
            tx_sh_d   = {regs_q[STATUS_REG][6:0], 1'b0};
            bit_cnt_d = 3'd0;
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            rx_sh_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            boundary  = (bit_cnt_q == 3'd7);
          end else if (sclk_fall) begin
            miso_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (boundary) begin
            if (state_q == CMD) begin
              state_d = DATA;
              ptr_d   = rx_byte[7:3];
              dir_d   = rx_byte[1];
              if (!rx_byte[1]) begin
                tx_sh_d = regs_q[rx_byte[7:3]];
                ptr_d   = rx_byte[7:3] + 5'd1;
              end
            end else if (dir_q) begin
              commit = 1'b1;
              ptr_d  = ptr_q + 5'd1;
            end else begin
              tx_sh_d = regs_q[ptr_q];
              ptr_d   = ptr_q + 5'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // register file: SPI commit overrides a same-address local write
  always_comb begin
    regs_d = regs_q;
    if (lcl_wr_en) regs_d[lcl_addr] = lcl_wdata;
    if (commit) regs_d[ptr_q] = rx_byte;
  end

  // registered local read and commit notification
  always_comb begin
    rdata_d  = regs_q[lcl_addr];
    strobe_d = commit;
    waddr_d  = commit ? ptr_q : waddr_q;
    wdata_d  = commit ? rx_byte : wdata_q;
  end

  // all state, synchronous active-low reset
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_qq_q   <= 1'b0;
      ss_qq_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      miso_q      <= 1'b0;
      ptr_q       <= 5'd0;
      dir_q       <= 1'b0;
      regs_q      <= '{default: 8'h00};
      rdata_q     <= 8'h00;
      strobe_q    <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 8'h00;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_qq_q   <= sclk_qq_d;
      ss_qq_q     <= ss_qq_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      miso_q      <= miso_d;
      ptr_q       <= ptr_d;
      dir_q       <= dir_d;
      regs_q      <= regs_d;
      rdata_q     <= rdata_d;
      strobe_q    <= strobe_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_spi_periph_regfile.sv
// Bench for spi_periph_regfile: bit-banged SPI master, transaction-level
// register model, strobe scoreboard and local read-back sweeps.
module tb_spi_periph_regfile;

  localparam int SYNC   = 2;
  localparam int STATUS = 25;
  localparam int H      = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       miso, miso_oe;
  logic       lcl_wr_en = 1'b0;
  logic [4:0] lcl_addr = 5'd0;
  logic [7:0] lcl_wdata = 8'h00;
  logic [7:0] lcl_rdata;
  logic       strobe;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [32];
  logic [12:0] got_q [$];
  logic [12:0] exp_q [$];
  logic [12:0] lst_q [$];
  logic [7:0]  txb [$];
  logic [7:0]  rxb [$];
  logic [7:0]  exp_rx [$];

  logic       chk_en = 1'b0;
  logic       armed = 1'b0;
  logic [4:0] pa = 5'd0;

  always #5 clk = ~clk;

  spi_periph_regfile #(
    .SYNC_STAGES(SYNC),
    .STATUS_REG (STATUS)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .spi_sclk     (sclk),
    .spi_mosi     (mosi),
    .spi_ss_n     (ss_n),
    .spi_miso     (miso),
    .spi_miso_oe  (miso_oe),
    .lcl_wr_en    (lcl_wr_en),
    .lcl_addr     (lcl_addr),
    .lcl_wdata    (lcl_wdata),
    .lcl_rdata    (lcl_rdata),
    .spi_wr_strobe(strobe),
    .spi_wr_addr  (wr_addr),
    .spi_wr_data  (wr_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // strobe scoreboard capture
  always @(negedge clk) begin
    if (strobe === 1'b1) got_q.push_back({wr_addr, wr_data});
  end

  // per-cycle local read-back compare against the model
  always @(negedge clk) begin
    if (chk_en && armed)
      chk($sformatf("rdata[%0d]", pa), 32'(lcl_rdata), 32'(mem[pa]));
    pa = lcl_addr;
    armed = chk_en;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lcl_write(input logic [4:0] a, input logic [7:0] d);
    lcl_addr = a;
    lcl_wdata = d;
    lcl_wr_en = 1'b1;
    step(1);
    lcl_wr_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic read_lcl(input logic [4:0] a, output logic [7:0] v);
    lcl_addr = a;
    step(1);
    v = lcl_rdata;
  endtask

  task automatic sweep();
    chk_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      lcl_addr = 5'(a);
      step(1);
    end
    step(1);
    chk_en = 1'b0;
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    step(6);
    chk("miso_oe selected", 32'(miso_oe), 32'd1);
  endtask

  task automatic ss_end();
    step(H);
    ss_n = 1'b1;
    step(8);
    chk("miso_oe idle", 32'(miso_oe), 32'd0);
  endtask

  // one SCLK period; optional local write lands on the commit edge
  task automatic shift_bit(input logic b, input logic coll,
                           input logic [4:0] ca, input logic [7:0] cd,
                           output logic s);
    mosi = b;
    step(H);
    s = miso;
    sclk = 1'b1;
    if (coll) begin
      step(SYNC);
      lcl_addr = ca;
      lcl_wdata = cd;
      lcl_wr_en = 1'b1;
      step(1);
      lcl_wr_en = 1'b0;
      step(H - SYNC - 1);
    end else begin
      step(H);
    end
    sclk = 1'b0;
  endtask

  // full SPI transaction from txb, nbits long, checked against the model
  task automatic txn(input int nbits, input logic coll,
                     input logic [4:0] ca, input logic [7:0] cd);
    logic [7:0] cmd, cur, rcv;
    logic [4:0] p;
    logic       s, cdone;
    int         full, n;
    cmd = txb[0];
    full = nbits / 8;
    p = cmd[7:3];
    cdone = 1'b0;
    exp_rx.delete();
    exp_rx.push_back(mem[STATUS]);
    for (int i = 1; i < full; i++) begin
      if (cmd[1]) begin
        if (coll && i == full - 1) begin
          mem[ca] = cd;
          cdone = 1'b1;
        end
        mem[p] = txb[i];
        exp_q.push_back({p, txb[i]});
      end else begin
        exp_rx.push_back(mem[p]);
      end
      p = p + 5'd1;
    end
    if (coll && !cdone) mem[ca] = cd;
    rxb.delete();
    rcv = 8'h00;
    ss_begin();
    for (int i = 0; i < nbits; i++) begin
      cur = txb[i / 8];
      shift_bit(cur[3'(7 - i % 8)], coll && (i == nbits - 1), ca, cd, s);
      rcv = {rcv[6:0], s};
      if (i % 8 == 7) rxb.push_back(rcv);
    end
    ss_end();
    for (int i = 0; i < exp_rx.size() && i < full; i++)
      chk($sformatf("miso byte%0d", i), 32'(rxb[i]), 32'(exp_rx[i]));
    chk("strobe count", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("strobe%0d addr/data", i), 32'(got_q[i]), 32'(exp_q[i]));
    lst_q = got_q;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    logic [7:0] v, cur;
    logic       s;
    int         kind, nd;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    step(3);
    chk("reset miso", 32'(miso), 32'd0);
    chk("reset miso_oe", 32'(miso_oe), 32'd0);
    chk("reset lcl_rdata", 32'(lcl_rdata), 32'd0);
    chk("reset strobe", 32'(strobe), 32'd0);
    rst_n = 1'b1;
    step(2);
    sweep();

    // single write
    txb.delete(); txb.push_back(8'h8A); txb.push_back(8'h5A);
    txn(16, 1'b0, 5'd0, 8'h00);
    chk("t1 strobes", 32'(lst_q.size()), 32'd1);
    chk("t1 strobe", 32'(lst_q[0]), 32'({5'd17, 8'h5A}));
    read_lcl(5'd17, v);
    chk("t1 reg17", 32'(v), 32'h5A);

    // read with status byte
    lcl_write(5'd3, 8'hC3);
    lcl_write(5'd25, 8'h81);
    txb.delete(); txb.push_back(8'h18); txb.push_back(8'h00);
    txn(16, 1'b0, 5'd0, 8'h00);
    chk("t2 byte0", 32'(rxb[0]), 32'h81);
    chk("t2 byte1", 32'(rxb[1]), 32'hC3);
    chk("t2 strobes", 32'(lst_q.size()), 32'd0);

    // burst wrap 31 -> 0
    txb.delete(); txb.push_back(8'hFA);
    txb.push_back(8'h11); txb.push_back(8'h22);
    txn(24, 1'b0, 5'd0, 8'h00);
    chk("t3 strobes", 32'(lst_q.size()), 32'd2);
    chk("t3 addr0", 32'(lst_q[0][12:8]), 32'd31);
    chk("t3 addr1", 32'(lst_q[1][12:8]), 32'd0);
    read_lcl(5'd31, v);
    chk("t3 reg31", 32'(v), 32'h11);
    read_lcl(5'd0, v);
    chk("t3 reg0", 32'(v), 32'h22);

    // abort after 5 data bits
    txb.delete(); txb.push_back(8'h8A); txb.push_back(8'hFF);
    txn(13, 1'b0, 5'd0, 8'h00);
    chk("t4 strobes", 32'(lst_q.size()), 32'd0);
    read_lcl(5'd17, v);
    chk("t4 reg17 kept", 32'(v), 32'h5A);
    txb.delete(); txb.push_back(8'h8A); txb.push_back(8'h77);
    txn(16, 1'b0, 5'd0, 8'h00);
    read_lcl(5'd17, v);
    chk("t4 reg17 new", 32'(v), 32'h77);

    // collisions with the local port on the commit edge
    txb.delete(); txb.push_back(8'h22); txb.push_back(8'hAA);
    txn(16, 1'b1, 5'd4, 8'h55);
    read_lcl(5'd4, v);
    chk("t5 reg4 same", 32'(v), 32'hAA);
    lcl_write(5'd4, 8'h01);
    txb.delete(); txb.push_back(8'h22); txb.push_back(8'hAA);
    txn(16, 1'b1, 5'd5, 8'h55);
    read_lcl(5'd4, v);
    chk("t5 reg4 diff", 32'(v), 32'hAA);
    read_lcl(5'd5, v);
    chk("t5 reg5 diff", 32'(v), 32'h55);
    sweep();

    // reset in the middle of a read
    lcl_addr = 5'd3;
    txb.delete(); txb.push_back(8'h18); txb.push_back(8'h00);
    ss_begin();
    for (int i = 0; i < 11; i++) begin
      cur = txb[i / 8];
      shift_bit(cur[3'(7 - i % 8)], 1'b0, 5'd0, 8'h00, s);
    end
    rst_n = 1'b0;
    step(2);
    chk("t6 miso", 32'(miso), 32'd0);
    chk("t6 miso_oe", 32'(miso_oe), 32'd0);
    chk("t6 lcl_rdata", 32'(lcl_rdata), 32'd0);
    chk("t6 strobe", 32'(strobe), 32'd0);
    ss_n = 1'b1;
    sclk = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    chk("t6 no strobe", 32'(got_q.size()), 32'd0);
    got_q.delete();
    txn(16, 1'b0, 5'd0, 8'h00);
    chk("t6 fresh read", 32'(rxb[1]), 32'h00);
    sweep();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      txb.delete();
      txb.push_back(8'($urandom));
      nd = $urandom_range(1, 4);
      repeat (nd) txb.push_back(8'($urandom));
      if (kind <= 3) begin
        txb[0][1] = 1'b1;
        txn(8 * (nd + 1), 1'b0, 5'd0, 8'h00);
      end else if (kind <= 6) begin
        txb[0][1] = 1'b0;
        txn(8 * (nd + 1), 1'b0, 5'd0, 8'h00);
      end else if (kind == 7) begin
        txn(8 * $urandom_range(0, nd) + $urandom_range(1, 7),
            1'b0, 5'd0, 8'h00);
      end else if (kind == 8) begin
        repeat ($urandom_range(1, 4))
          lcl_write(5'($urandom), 8'($urandom));
      end else begin
        repeat (8) begin
          mosi = 1'($urandom);
          sclk = 1'b1;
          step(H);
          sclk = 1'b0;
          step(H);
        end
        step(6);
        chk("idle sclk strobes", 32'(got_q.size()), 32'd0);
        got_q.delete();
      end
      sweep();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
